// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - Shared opcode, status and state encodings for the key/value store.
package kv_pkg;

  localparam int OP_W     = 3;
  localparam int STATUS_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SET     = 3'd0,
    OP_GET     = 3'd1,
    OP_DELETE  = 3'd2,
    OP_ENCODE  = 3'd3,
    OP_SET_IDX = 3'd4,
    OP_GET_IDX = 3'd5,
    OP_CLEAR   = 3'd6
  } kv_op_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK     = 2'd0,
    ST_MISS   = 2'd1,
    ST_FULL   = 2'd2,
    ST_BADIDX = 2'd3
  } kv_status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } kv_state_e;

endpackage

// File: rtl/kv_match.sv
// rtl/kv_match.sv - Parallel key compare gated by valid, with lowest-index priority encoders
// for the first hit and the first free slot.
module kv_match
  import kv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int KEY_W   = 32,
  parameter int IDX_W   = 4
) (
  input  logic [ENTRIES-1:0][KEY_W-1:0] keys,
  input  logic [ENTRIES-1:0]            valid,
  input  logic [KEY_W-1:0]              key,
  output logic                          hit,
  output logic [IDX_W-1:0]              hit_idx,
  output logic                          free,
  output logic [IDX_W-1:0]              free_idx
);

  logic [ENTRIES-1:0] eq;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      eq[i] = valid[i] && (keys[i] == key);
    end
  end

  // Walk downwards so the lowest index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (eq[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kv_store.sv
// rtl/kv_store.sv - Key/value store with request/response handshake and 2-cycle lookups.
// Define KV_STORE_LRU_EN to evict the least recently used slot on a SET to a full store.
module kv_store
  import kv_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int KEY_W   = 32,
  parameter  int VAL_W   = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_op,
  input  logic [KEY_W-1:0] i_key,
  input  logic [VAL_W-1:0] i_value,
  input  logic [IDX_W-1:0] i_index,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [VAL_W-1:0] o_value,
  output logic [IDX_W-1:0] o_index,
  output logic [1:0]       o_status,
  output logic [IDX_W:0]   o_count,
  output logic             o_full
);

  kv_state_e state_q, state_d;

  kv_op_e           op_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [IDX_W-1:0] idx_q;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][KEY_W-1:0] key_mem;
  logic [ENTRIES-1:0][VAL_W-1:0] val_mem;
  logic [IDX_W:0]                count_q;

  logic             hit, free;
  logic [IDX_W-1:0] hit_idx, free_idx;

  logic             wr, rm, inc, dec, idx_ok, accept;
  logic [IDX_W-1:0] wr_idx, rm_idx;
  logic [VAL_W-1:0] r_value;
  logic [IDX_W-1:0] r_index;
  kv_status_e       r_status;

`ifdef KV_STORE_LRU_EN
  logic [ENTRIES-1:0][IDX_W-1:0] age_q, age_a, age_d;
  logic [ENTRIES-1:0]            valid_a;
  logic [IDX_W-1:0]              victim;
  logic                          touch;
`endif

  assign o_req_ready = (state_q == S_IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign o_count     = count_q;
  assign o_full      = (count_q == (IDX_W+1)'(ENTRIES));

  kv_match #(
    .ENTRIES (ENTRIES),
    .KEY_W   (KEY_W),
    .IDX_W   (IDX_W)
  ) u_match (
    .keys     (key_mem),
    .valid    (valid_q),
    .key      (key_q),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .free     (free),
    .free_idx (free_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_req_valid) state_d = (kv_op_e'(i_op) == OP_CLEAR) ? S_RESP : S_LOOKUP;
      S_LOOKUP: state_d = S_RESP;
      S_RESP:   if (i_rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr       = 1'b0;
    rm       = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    wr_idx   = '0;
    rm_idx   = '0;
    r_value  = '0;
    r_index  = '0;
    r_status = ST_OK;
    idx_ok   = ({1'b0, idx_q} < (IDX_W+1)'(ENTRIES));
    if (state_q == S_LOOKUP) begin
      case (op_q)
        OP_SET: begin
          if (hit) begin
            wr     = 1'b1;
            wr_idx = hit_idx;
          end else if (free) begin
            wr     = 1'b1;
            wr_idx = free_idx;
            inc    = 1'b1;
          end else begin
`ifdef KV_STORE_LRU_EN
            wr      = 1'b1;
            wr_idx  = victim;
            r_value = val_mem[victim];
`else
            r_status = ST_FULL;
`endif
          end
          r_index = wr_idx;
        end
        OP_GET: begin
          if (hit) begin
            r_value = val_mem[hit_idx];
            r_index = hit_idx;
          end else begin
            r_status = ST_MISS;
          end
        end
        OP_DELETE: begin
          if (hit) begin
            rm      = 1'b1;
            rm_idx  = hit_idx;
            dec     = 1'b1;
            r_value = val_mem[hit_idx];
            r_index = hit_idx;
          end else begin
            r_status = ST_MISS;
          end
        end
        OP_ENCODE: begin
          if (hit) r_index  = hit_idx;
          else     r_status = ST_MISS;
        end
        OP_SET_IDX: begin
          if (!idx_ok) begin
            r_status = ST_BADIDX;
          end else begin
            wr      = 1'b1;
            wr_idx  = idx_q;
            inc     = !valid_q[idx_q];
            r_index = idx_q;
            // The key may already live in another slot; drop that copy.
            if (hit && (hit_idx != idx_q)) begin
              rm     = 1'b1;
              rm_idx = hit_idx;
              dec    = 1'b1;
            end
          end
        end
        OP_GET_IDX: begin
          if (!idx_ok) begin
            r_status = ST_BADIDX;
          end else if (valid_q[idx_q]) begin
            r_value = val_mem[idx_q];
            r_index = idx_q;
          end else begin
            r_status = ST_MISS;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q     <= '0;
      count_q     <= '0;
      o_rsp_valid <= 1'b0;
      o_value     <= '0;
      o_index     <= '0;
      o_status    <= ST_OK;
      op_q        <= OP_SET;
      key_q       <= '0;
      val_q       <= '0;
      idx_q       <= '0;
    end else begin
      if (accept) begin
        op_q  <= kv_op_e'(i_op);
        key_q <= i_key;
        val_q <= i_value;
        idx_q <= i_index;
        if (kv_op_e'(i_op) == OP_CLEAR) begin
          valid_q     <= '0;
          count_q     <= '0;
          o_rsp_valid <= 1'b1;
          o_value     <= '0;
          o_index     <= '0;
          o_status    <= ST_OK;
        end
      end
      if (state_q == S_LOOKUP) begin
        if (wr) valid_q[wr_idx] <= 1'b1;
        if (rm) valid_q[rm_idx] <= 1'b0;
        count_q     <= count_q + (IDX_W+1)'(inc) - (IDX_W+1)'(dec);
        o_rsp_valid <= 1'b1;
        o_value     <= r_value;
        o_index     <= r_index;
        o_status    <= r_status;
      end
      if ((state_q == S_RESP) && i_rsp_ready) o_rsp_valid <= 1'b0;
    end
  end

  // Storage carries no reset; occupancy is owned entirely by valid_q.
  always_ff @(posedge i_clk) begin
    if (wr) begin
      key_mem[wr_idx] <= key_q;
      val_mem[wr_idx] <= val_q;
    end
  end

`ifdef KV_STORE_LRU_EN
  // Valid slots hold distinct ages 0..count-1, so a full store always has one slot at ENTRIES-1.
  always_comb begin
    victim = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (age_q[i] == IDX_W'(ENTRIES - 1))) victim = IDX_W'(i);
    end
  end

  always_comb begin
    touch = (state_q == S_LOOKUP) && (r_status == ST_OK) && (op_q != OP_DELETE) &&
            (op_q inside {OP_SET, OP_GET, OP_ENCODE, OP_SET_IDX, OP_GET_IDX});
    valid_a = valid_q;
    if (rm) valid_a[rm_idx] = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      age_a[i] = (rm && valid_q[i] && (age_q[i] > age_q[rm_idx])) ? age_q[i] - IDX_W'(1) : age_q[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_a[i];
      if (touch) begin
        if (IDX_W'(i) == r_index)
          age_d[i] = '0;
        else if (valid_a[i] && (!valid_a[r_index] || (age_a[i] < age_a[r_index])))
          age_d[i] = age_a[i] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) age_q <= '0;
    else       age_q <= age_d;
  end
`endif

endmodule

// File: tb/tb_kv_store.sv
// tb/tb_kv_store.sv - Directed table-driven bench for kv_store plus multi-cycle corner sequences.
module tb_kv_store;

  localparam logic [2:0] SET = 3'd0, GET = 3'd1, DEL = 3'd2, ENC = 3'd3;
  localparam logic [2:0] SETI = 3'd4, GETI = 3'd5, CLR = 3'd6;
  localparam logic [1:0] OK = 2'd0, MISS = 2'd1, FULL = 2'd2, BADIDX = 2'd3;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] key;
    logic [31:0] val;
    logic [3:0]  idx;
    logic [1:0]  st;
    logic [31:0] value;
    logic        chk_val;
    logic [3:0]  index;
    logic        chk_idx;
    logic [4:0]  count;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, rsp_ready;
  logic [2:0]  op;
  logic [31:0] key, val;
  logic [3:0]  idx;

  logic        req_ready, rsp_valid, full;
  logic [31:0] value;
  logic [3:0]  index;
  logic [1:0]  status;
  logic [4:0]  count;

  logic        b_req_ready, b_rsp_valid, b_full;
  logic [31:0] b_value;
  logic [3:0]  b_index;
  logic [1:0]  b_status;
  logic [4:0]  b_count;
  logic [1:0]  last_b_status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kv_store #(.ENTRIES(16), .KEY_W(32), .VAL_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_op(op), .i_key(key), .i_value(val), .i_index(idx),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_value(value), .o_index(index),
    .o_status(status), .o_count(count), .o_full(full)
  );

  // Non-power-of-two depth so an in-range-width index can still be out of range.
  kv_store #(.ENTRIES(12), .KEY_W(32), .VAL_W(32)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_op(op), .i_key(key), .i_value(val), .i_index(idx),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_value(b_value), .o_index(b_index),
    .o_status(b_status), .o_count(b_count), .o_full(b_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] k, input logic [31:0] v,
                              input logic [3:0] ix, input logic [1:0] s, input logic [31:0] ev,
                              input logic cv, input logic [3:0] ei, input logic ci,
                              input logic [4:0] ec, input int l);
    vec_t r;
    r.op = o; r.key = k; r.val = v; r.idx = ix; r.st = s; r.value = ev; r.chk_val = cv;
    r.index = ei; r.chk_idx = ci; r.count = ec; r.lat = l;
    return r;
  endfunction

  task automatic run(input vec_t v, input int hold, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; op = v.op; key = v.key; val = v.val; idx = v.idx;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_status"}, 32'(status), 32'(v.st));
    if (v.chk_val) chk({tag, "_value"}, value, v.value);
    if (v.chk_idx) chk({tag, "_index"}, 32'(index), 32'(v.index));
    chk({tag, "_count"}, 32'(count), 32'(v.count));
    last_b_status = b_status;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_value"}, value, v.value);
      chk({tag, "_hold_index"}, 32'(index), 32'(v.index));
      chk({tag, "_hold_status"}, 32'(status), 32'(v.st));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
  endtask

  vec_t tbl[18];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    op = '0; key = '0; val = '0; idx = '0; last_b_status = '0;

    tbl[0]  = mk(SET,  32'h11, 32'hAA, 4'd0, OK,   32'hAA, 1'b0, 4'd0, 1'b1, 5'd1, 2);
    tbl[1]  = mk(GET,  32'h11, 32'h0,  4'd0, OK,   32'hAA, 1'b1, 4'd0, 1'b1, 5'd1, 2);
    tbl[2]  = mk(SET,  32'h22, 32'hBB, 4'd0, OK,   32'h0,  1'b0, 4'd1, 1'b1, 5'd2, 2);
    tbl[3]  = mk(SET,  32'h11, 32'hCC, 4'd0, OK,   32'h0,  1'b0, 4'd0, 1'b1, 5'd2, 2);
    tbl[4]  = mk(GET,  32'h11, 32'h0,  4'd0, OK,   32'hCC, 1'b1, 4'd0, 1'b1, 5'd2, 2);
    tbl[5]  = mk(ENC,  32'h22, 32'h0,  4'd0, OK,   32'h0,  1'b0, 4'd1, 1'b1, 5'd2, 2);
    tbl[6]  = mk(ENC,  32'h99, 32'h0,  4'd0, MISS, 32'h0,  1'b0, 4'd0, 1'b1, 5'd2, 2);
    tbl[7]  = mk(GET,  32'h99, 32'h0,  4'd0, MISS, 32'h0,  1'b1, 4'd0, 1'b1, 5'd2, 2);
    tbl[8]  = mk(DEL,  32'h22, 32'h0,  4'd0, OK,   32'hBB, 1'b1, 4'd1, 1'b1, 5'd1, 2);
    tbl[9]  = mk(DEL,  32'h22, 32'h0,  4'd0, MISS, 32'h0,  1'b0, 4'd0, 1'b0, 5'd1, 2);
    tbl[10] = mk(SETI, 32'h33, 32'h55, 4'd5, OK,   32'h0,  1'b0, 4'd5, 1'b1, 5'd2, 2);
    tbl[11] = mk(GETI, 32'h0,  32'h0,  4'd5, OK,   32'h55, 1'b1, 4'd5, 1'b1, 5'd2, 2);
    tbl[12] = mk(GETI, 32'h0,  32'h0,  4'd7, MISS, 32'h0,  1'b0, 4'd0, 1'b0, 5'd2, 2);
    tbl[13] = mk(SETI, 32'h11, 32'h66, 4'd6, OK,   32'h0,  1'b0, 4'd6, 1'b1, 5'd2, 2);
    tbl[14] = mk(GET,  32'h11, 32'h0,  4'd0, OK,   32'h66, 1'b1, 4'd6, 1'b1, 5'd2, 2);
    tbl[15] = mk(SET,  32'h44, 32'h77, 4'd0, OK,   32'h0,  1'b0, 4'd0, 1'b1, 5'd3, 2);
    tbl[16] = mk(CLR,  32'h0,  32'h0,  4'd0, OK,   32'h0,  1'b0, 4'd0, 1'b0, 5'd0, 1);
    tbl[17] = mk(GET,  32'h33, 32'h0,  4'd0, MISS, 32'h0,  1'b1, 4'd0, 1'b1, 5'd0, 2);

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {value[15:0], 6'd0, index, 4'd0, status}, 32'd0);

    for (int i = 0; i < 18; i++) run(tbl[i], 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++)
      run(mk(SET, 32'h100 + i, 32'h200 + i, 4'd0, OK, 32'h0, 1'b0, 4'(i), 1'b1, 5'(i + 1), 2),
          0, $sformatf("fill%0d", i));
    chk("full_flag", 32'(full), 32'd1);
`ifdef KV_STORE_LRU_EN
    run(mk(SET, 32'h999, 32'h1, 4'd0, OK, 32'h200, 1'b1, 4'd0, 1'b1, 5'd16, 2), 0, "evict");
`else
    run(mk(SET, 32'h999, 32'h1, 4'd0, FULL, 32'h0, 1'b0, 4'd0, 1'b0, 5'd16, 2), 0, "set_full");
`endif

    run(mk(DEL, 32'h103, 32'h0, 4'd0, OK, 32'h203, 1'b1, 4'd3, 1'b1, 5'd15, 2), 0, "del3");
    chk("not_full_after_del", 32'(full), 32'd0);
    run(mk(SET, 32'h555, 32'h5, 4'd0, OK, 32'h0, 1'b0, 4'd3, 1'b1, 5'd16, 2), 0, "reuse3");
    run(mk(GET, 32'h103, 32'h0, 4'd0, MISS, 32'h0, 1'b1, 4'd0, 1'b1, 5'd16, 2), 0, "get_deleted");
    run(mk(GET, 32'h555, 32'h0, 4'd0, OK, 32'h5, 1'b1, 4'd3, 1'b1, 5'd16, 2), 5, "stall");

    run(mk(GETI, 32'h0, 32'h0, 4'd14, OK, 32'h20E, 1'b1, 4'd14, 1'b1, 5'd16, 2), 0, "geti14");
    chk("badidx14_e12", 32'(last_b_status), 32'(BADIDX));
    run(mk(GETI, 32'h0, 32'h0, 4'd12, OK, 32'h20C, 1'b1, 4'd12, 1'b1, 5'd16, 2), 0, "geti12");
    chk("badidx12_e12", 32'(last_b_status), 32'(BADIDX));

    // Reset lands while the SET is in LOOKUP.
    run(mk(CLR, 32'h0, 32'h0, 4'd0, OK, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 1), 0, "clr_pre");
    @(negedge clk);
    req_valid = 1'b1; op = SET; key = 32'h77; val = 32'h1; idx = '0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_status", 32'(status), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    run(mk(GET, 32'h77, 32'h0, 4'd0, MISS, 32'h0, 1'b1, 4'd0, 1'b1, 5'd0, 2), 0, "abort_get");

    for (int i = 0; i < 5; i++)
      run(mk(SET, 32'h300 + i, 32'h40 + i, 4'd0, OK, 32'h0, 1'b0, 4'(i), 1'b1, 5'(i + 1), 2),
          0, $sformatf("five%0d", i));
    run(mk(CLR, 32'h0, 32'h0, 4'd0, OK, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 1), 0, "clear5");
    run(mk(GET, 32'h302, 32'h0, 4'd0, MISS, 32'h0, 1'b1, 4'd0, 1'b1, 5'd0, 2), 0, "after_clear");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
